// File: rtl/gc_controller_param.sv
// gc_controller_param
//
// Garbage-collection controller for the NVM remapping path. Keeps a
// per-block invalid-page counter, a closed bit per block, a free-block FIFO
// and the current active block. When the free pool runs low it asks the
// overall controller for a GC pass. On grant it scans every block for the
// closed, non-active block with the most invalid pages, has the remapping
// table move that block's valid pages (skipped when none are valid), then
// erases the block and returns it to the free pool.
//
// Ports
//   CLK                 in   clock, rising edge
//   nRST                in   synchronous active-low reset
//   gc_ini              in   pulse: rebuild free pool, clear all counters
//   gc_start            in   GC grant, honoured only while requesting
//   invalid_flag        in   one page of invalid_blk_num became invalid
//   invalid_blk_num     in   block owning the invalidated page
//   new_active_request  in   remapping table wants a fresh active block
//   move_done_flag      in   page move of erase_blk_num finished
//   gc_request          out  background GC wanted
//   gc_interrupt        out  urgent GC wanted (free pool critically low)
//   req_done            out  pulse: GC pass complete
//   erase_blk_num       out  victim block of the last scan
//   active_blk_num      out  current active block
//   move_flag           out  page move of erase_blk_num requested
//   free_cnt            out  blocks held in the free FIFO
//   busy                out  pass or initialisation in progress
//
// state  | meaning
// -------+-----------------------------------------------------------
// UNINIT | after reset, waiting for gc_ini; no requests raised
// INIT   | one block per cycle: clear counters, refill the free FIFO
// IDLE   | free pool healthy
// REQ    | free pool low, gc_request (and maybe gc_interrupt) raised
// SCAN   | walk all blocks, keep the most-invalid closed candidate
// MOVE   | waiting for the remapping table to move valid pages
// ERASE  | clear victim counters, push victim onto the free FIFO
// DONE   | req_done pulse

module gc_controller_param #(
    parameter int BLK_W         = 8,
    parameter int PAGES_PER_BLK = 64,
    parameter int FREE_HIGH     = 8,
    parameter int FREE_LOW      = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             gc_ini,
    input  logic             gc_start,
    input  logic             invalid_flag,
    input  logic [BLK_W-1:0] invalid_blk_num,
    input  logic             new_active_request,
    input  logic             move_done_flag,
    output logic             gc_request,
    output logic             gc_interrupt,
    output logic             req_done,
    output logic [BLK_W-1:0] erase_blk_num,
    output logic [BLK_W-1:0] active_blk_num,
    output logic             move_flag,
    output logic [BLK_W:0]   free_cnt,
    output logic             busy
);

    localparam int NUM_BLK = 1 << BLK_W;
    localparam int PC_W    = $clog2(PAGES_PER_BLK + 1);

    localparam logic [PC_W-1:0]  PC_MAX      = PC_W'(PAGES_PER_BLK);
    localparam logic [BLK_W-1:0] LAST_IDX    = BLK_W'(NUM_BLK - 1);
    localparam logic [BLK_W-1:0] ONE_BLK     = BLK_W'(1);
    localparam logic [BLK_W:0]   ONE_FC      = (BLK_W + 1)'(1);
    localparam logic [BLK_W:0]   FREE_HIGH_C = (BLK_W + 1)'(FREE_HIGH);
    localparam logic [BLK_W:0]   FREE_LOW_C  = (BLK_W + 1)'(FREE_LOW);

    typedef enum logic [2:0] {
        ST_UNINIT,
        ST_INIT,
        ST_IDLE,
        ST_REQ,
        ST_SCAN,
        ST_MOVE,
        ST_ERASE,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BLK_W-1:0] idx_q, idx_d;
    logic [BLK_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [BLK_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [BLK_W:0]   free_cnt_q, free_cnt_d;
    logic [BLK_W-1:0] active_q, active_d;
    logic [BLK_W-1:0] erase_blk_q, erase_blk_d;
    logic [BLK_W-1:0] best_blk_q, best_blk_d;
    logic [PC_W-1:0]  best_cnt_q, best_cnt_d;
    logic             best_vld_q, best_vld_d;
    logic             gc_request_q, gc_request_d;
    logic             gc_interrupt_q, gc_interrupt_d;
    logic             req_done_q, req_done_d;
    logic             move_flag_q, move_flag_d;
    logic             busy_q, busy_d;

    logic [PC_W-1:0]  inv_cnt_q [NUM_BLK];
    logic             closed_q  [NUM_BLK];
    logic [BLK_W-1:0] fifo_q    [NUM_BLK];

    // Array write controls
    logic             inc_en;
    logic [BLK_W-1:0] inc_blk;
    logic             clr_en;
    logic [BLK_W-1:0] clr_blk;
    logic             close_en;
    logic [BLK_W-1:0] close_blk;
    logic             push_en;
    logic [BLK_W-1:0] push_data;
    logic             pop_en;

    logic             live;
    logic             cand;
    logic             take;
    logic             nb_vld;
    logic [PC_W-1:0]  nb_cnt;
    logic [BLK_W-1:0] nb_blk;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        free_cnt_d  = free_cnt_q;
        active_d    = active_q;
        erase_blk_d = erase_blk_q;
        best_blk_d  = best_blk_q;
        best_cnt_d  = best_cnt_q;
        best_vld_d  = best_vld_q;

        inc_en    = 1'b0;
        inc_blk   = invalid_blk_num;
        clr_en    = 1'b0;
        clr_blk   = idx_q;
        close_en  = 1'b0;
        close_blk = active_q;
        push_en   = 1'b0;
        push_data = idx_q;
        pop_en    = 1'b0;

        cand   = 1'b0;
        take   = 1'b0;
        nb_vld = best_vld_q;
        nb_cnt = best_cnt_q;
        nb_blk = best_blk_q;

        live = (state_q != ST_UNINIT) && (state_q != ST_INIT);

        if (live && invalid_flag) begin
            inc_en = 1'b1;
        end

        if (gc_ini) begin
            // Restart from an empty pool; INIT refills it one block per cycle.
            state_d    = ST_INIT;
            idx_d      = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            free_cnt_d = '0;
            best_vld_d = 1'b0;
            best_cnt_d = '0;
            best_blk_d = '0;
        end else begin
            case (state_q)
                ST_UNINIT: begin
                    state_d = ST_UNINIT;
                end

                ST_INIT: begin
                    clr_en  = 1'b1;
                    clr_blk = idx_q;
                    // Block 0 becomes the first active block, so it is not queued.
                    if (idx_q != '0) begin
                        push_en   = 1'b1;
                        push_data = idx_q;
                    end
                    idx_d = idx_q + ONE_BLK;
                    if (idx_q == LAST_IDX) begin
                        state_d  = ST_IDLE;
                        active_d = '0;
                    end
                end

                ST_IDLE: begin
                    if (free_cnt_q < FREE_HIGH_C) begin
                        state_d = ST_REQ;
                    end
                end

                ST_REQ: begin
                    if (gc_start) begin
                        state_d    = ST_SCAN;
                        idx_d      = '0;
                        best_vld_d = 1'b0;
                        best_cnt_d = '0;
                        best_blk_d = '0;
                    end else if (free_cnt_q >= FREE_HIGH_C) begin
                        state_d = ST_IDLE;
                    end
                end

                ST_SCAN: begin
                    cand = closed_q[idx_q] && (idx_q != active_q);
                    // Strict compare keeps the lower index on ties.
                    take = cand && (!best_vld_q || (inv_cnt_q[idx_q] > best_cnt_q));
                    if (take) begin
                        nb_vld = 1'b1;
                        nb_cnt = inv_cnt_q[idx_q];
                        nb_blk = idx_q;
                    end
                    best_vld_d = nb_vld;
                    best_cnt_d = nb_cnt;
                    best_blk_d = nb_blk;
                    idx_d      = idx_q + ONE_BLK;
                    if (idx_q == LAST_IDX) begin
                        erase_blk_d = nb_blk;
                        if (!nb_vld || (nb_cnt == '0)) begin
                            state_d = ST_DONE;
                        end else if (nb_cnt == PC_MAX) begin
                            state_d = ST_ERASE;
                        end else begin
                            state_d = ST_MOVE;
                        end
                    end
                end

                ST_MOVE: begin
                    if (move_done_flag) begin
                        state_d = ST_ERASE;
                    end
                end

                ST_ERASE: begin
                    clr_en    = 1'b1;
                    clr_blk   = erase_blk_q;
                    push_en   = 1'b1;
                    push_data = erase_blk_q;
                    state_d   = ST_DONE;
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_UNINIT;
                end
            endcase

            if (live && new_active_request && (free_cnt_q != '0)) begin
                pop_en = 1'b1;
            end
        end

        if (pop_en) begin
            close_en  = 1'b1;
            close_blk = active_q;
            active_d  = fifo_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + ONE_BLK;
        end

        if (push_en) begin
            wr_ptr_d = wr_ptr_q + ONE_BLK;
        end

        if (push_en && !pop_en) begin
            free_cnt_d = free_cnt_q + ONE_FC;
        end else if (pop_en && !push_en) begin
            free_cnt_d = free_cnt_q - ONE_FC;
        end

        // Outputs are registered from the next state so they line up with it.
        gc_request_d   = (state_d == ST_REQ);
        gc_interrupt_d = (state_d == ST_REQ) && (free_cnt_d <= FREE_LOW_C);
        req_done_d     = (state_d == ST_DONE);
        move_flag_d    = (state_d == ST_MOVE);
        busy_d         = (state_d == ST_INIT) || (state_d == ST_SCAN) ||
                         (state_d == ST_MOVE) || (state_d == ST_ERASE) ||
                         (state_d == ST_DONE);
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q        <= ST_UNINIT;
            idx_q          <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            free_cnt_q     <= '0;
            active_q       <= '0;
            erase_blk_q    <= '0;
            best_blk_q     <= '0;
            best_cnt_q     <= '0;
            best_vld_q     <= 1'b0;
            gc_request_q   <= 1'b0;
            gc_interrupt_q <= 1'b0;
            req_done_q     <= 1'b0;
            move_flag_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            free_cnt_q     <= free_cnt_d;
            active_q       <= active_d;
            erase_blk_q    <= erase_blk_d;
            best_blk_q     <= best_blk_d;
            best_cnt_q     <= best_cnt_d;
            best_vld_q     <= best_vld_d;
            gc_request_q   <= gc_request_d;
            gc_interrupt_q <= gc_interrupt_d;
            req_done_q     <= req_done_d;
            move_flag_q    <= move_flag_d;
            busy_q         <= busy_d;
        end
    end

    // A clear in the same cycle as an increment of the same block wins,
    // which drops invalidations of the victim during its erase cycle.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < NUM_BLK; i++) begin
                inv_cnt_q[i] <= '0;
                closed_q[i]  <= 1'b0;
            end
        end else begin
            if (inc_en && (inv_cnt_q[inc_blk] != PC_MAX)) begin
                inv_cnt_q[inc_blk] <= inv_cnt_q[inc_blk] + PC_W'(1);
            end
            if (close_en) begin
                closed_q[close_blk] <= 1'b1;
            end
            if (clr_en) begin
                inv_cnt_q[clr_blk] <= '0;
                closed_q[clr_blk]  <= 1'b0;
            end
        end
    end

    // FIFO storage needs no reset: entries are only read below free_cnt.
    always_ff @(posedge CLK) begin
        if (push_en) begin
            fifo_q[wr_ptr_q] <= push_data;
        end
    end

    assign gc_request     = gc_request_q;
    assign gc_interrupt   = gc_interrupt_q;
    assign req_done       = req_done_q;
    assign erase_blk_num  = erase_blk_q;
    assign active_blk_num = active_q;
    assign move_flag      = move_flag_q;
    assign free_cnt       = free_cnt_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_gc_controller_param.sv
// Directed bench for gc_controller_param at BLK_W=4, PAGES_PER_BLK=4,
// FREE_HIGH=8, FREE_LOW=2. Inputs change 1 time unit after a rising edge and
// outputs are sampled there as well.

module tb_gc_controller_param;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       gc_ini;
    logic       gc_start;
    logic       invalid_flag;
    logic [3:0] invalid_blk_num;
    logic       new_active_request;
    logic       move_done_flag;
    logic       gc_request;
    logic       gc_interrupt;
    logic       req_done;
    logic [3:0] erase_blk_num;
    logic [3:0] active_blk_num;
    logic       move_flag;
    logic [4:0] free_cnt;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    gc_controller_param #(
        .BLK_W(4),
        .PAGES_PER_BLK(4),
        .FREE_HIGH(8),
        .FREE_LOW(2)
    ) dut (
        .CLK(CLK),
        .nRST(nRST),
        .gc_ini(gc_ini),
        .gc_start(gc_start),
        .invalid_flag(invalid_flag),
        .invalid_blk_num(invalid_blk_num),
        .new_active_request(new_active_request),
        .move_done_flag(move_done_flag),
        .gc_request(gc_request),
        .gc_interrupt(gc_interrupt),
        .req_done(req_done),
        .erase_blk_num(erase_blk_num),
        .active_blk_num(active_blk_num),
        .move_flag(move_flag),
        .free_cnt(free_cnt),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic alloc();
        new_active_request = 1'b1;
        tick();
        new_active_request = 1'b0;
    endtask

    task automatic inval(input logic [3:0] b);
        invalid_flag    = 1'b1;
        invalid_blk_num = b;
        tick();
        invalid_flag    = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (gc_request !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 32'(gc_request), 1);
    endtask

    task automatic grant();
        gc_start = 1'b1;
        tick();
        gc_start = 1'b0;
    endtask

    // Pulse gc_ini and follow INIT to its end.
    task automatic init_run(input string tag);
        int   n;
        logic rd;
        gc_ini = 1'b1;
        tick();
        gc_ini = 1'b0;
        chk({tag, "_move_flag"}, 32'(move_flag), 0);
        n  = 0;
        rd = 1'b0;
        while (busy === 1'b1 && n < 40) begin
            rd = rd | req_done;
            n++;
            tick();
        end
        chk({tag, "_busy_cycles"}, 32'(n), 16);
        chk({tag, "_no_req_done"}, 32'(rd), 0);
        chk({tag, "_free_cnt"}, 32'(free_cnt), 15);
        chk({tag, "_active"}, 32'(active_blk_num), 0);
        chk({tag, "_gc_request"}, 32'(gc_request), 0);
    endtask

    initial begin
        int         n;
        logic       seen;
        logic [3:0] fifo_order [4];

        nRST               = 1'b0;
        gc_ini             = 1'b0;
        gc_start           = 1'b0;
        invalid_flag       = 1'b0;
        invalid_blk_num    = '0;
        new_active_request = 1'b0;
        move_done_flag     = 1'b0;
        fifo_order[0] = 4'd14;
        fifo_order[1] = 4'd15;
        fifo_order[2] = 4'd3;
        fifo_order[3] = 4'd6;

        repeat (3) tick();
        chk("reset_outputs", 32'({gc_request, gc_interrupt, req_done, move_flag, busy,
                                  erase_blk_num, active_blk_num, free_cnt}), 0);
        nRST = 1'b1;

        // Without gc_ini nothing may wake up, whatever the other inputs do.
        gc_start           = 1'b1;
        new_active_request = 1'b1;
        invalid_flag       = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | gc_request | gc_interrupt | busy | (free_cnt != 0);
        end
        gc_start           = 1'b0;
        new_active_request = 1'b0;
        invalid_flag       = 1'b0;
        chk("uninit_quiet", 32'(seen), 0);

        init_run("init");

        // Allocation order and request thresholds.
        for (int i = 0; i < 8; i++) begin
            alloc();
            chk("alloc_active", 32'(active_blk_num), 32'(i + 1));
        end
        chk("free_after_8", 32'(free_cnt), 7);
        tick();
        chk("bg_request", 32'(gc_request), 1);
        chk("bg_no_interrupt", 32'(gc_interrupt), 0);
        for (int i = 0; i < 4; i++) alloc();
        chk("free_3_no_interrupt", 32'(gc_interrupt), 0);
        alloc();
        chk("free_after_13", 32'(free_cnt), 2);
        chk("urgent_interrupt", 32'(gc_interrupt), 1);
        chk("active_13", 32'(active_blk_num), 13);

        // Pass with page move: tie between blk 3 and blk 5.
        inval(4'd3);
        inval(4'd3);
        inval(4'd5);
        inval(4'd5);
        wait_req("req_before_pass1");
        grant();
        chk("grant_drops_request", 32'({gc_request, gc_interrupt}), 0);
        chk("scan_busy", 32'(busy), 1);
        n = 0;
        while (move_flag !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("scan_cycles", 32'(n), 16);
        chk("victim_tie_low", 32'(erase_blk_num), 3);
        repeat (5) tick();
        chk("move_flag_held", 32'(move_flag), 1);
        move_done_flag = 1'b1;
        tick();
        move_done_flag = 1'b0;
        chk("move_flag_drop", 32'(move_flag), 0);
        tick();
        chk("pass1_req_done", 32'(req_done), 1);
        chk("pass1_free_cnt", 32'(free_cnt), 3);
        tick();
        chk("req_done_pulse", 32'(req_done), 0);

        // Fully invalid victim (extra invalidation checks saturation).
        repeat (5) inval(4'd6);
        wait_req("req_before_pass2");
        chk("free3_interrupt_low", 32'(gc_interrupt), 0);
        grant();
        n    = 0;
        seen = 1'b0;
        while (req_done !== 1'b1 && n < 40) begin
            tick();
            n++;
            seen = seen | move_flag;
        end
        chk("erase_only_latency", 32'(n + 1), 18);
        chk("erase_only_victim", 32'(erase_blk_num), 6);
        chk("erase_only_no_move", 32'(seen), 0);
        chk("erase_only_free", 32'(free_cnt), 4);

        // Erased blocks were appended at the FIFO tail.
        for (int i = 0; i < 4; i++) begin
            alloc();
            chk("fifo_tail_order", 32'(active_blk_num), 32'(fifo_order[i]));
        end
        chk("fifo_empty", 32'(free_cnt), 0);
        alloc();
        chk("empty_alloc_active", 32'(active_blk_num), 6);
        chk("empty_alloc_free", 32'(free_cnt), 0);

        // Pass with nothing to reclaim.
        init_run("reinit");
        repeat (8) alloc();
        wait_req("req_before_pass3");
        grant();
        n    = 0;
        seen = 1'b0;
        while (req_done !== 1'b1 && n < 40) begin
            tick();
            n++;
            seen = seen | move_flag;
        end
        chk("zero_pass_latency", 32'(n + 1), 17);
        chk("zero_pass_no_move", 32'(seen), 0);
        chk("zero_pass_free", 32'(free_cnt), 7);

        // gc_ini aborts a pass sitting in MOVE.
        inval(4'd2);
        wait_req("req_before_pass4");
        grant();
        n = 0;
        while (move_flag !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("abort_victim", 32'(erase_blk_num), 2);
        init_run("abort");

        // Pop and push in the ERASE cycle leave free_cnt unchanged.
        repeat (12) alloc();
        chk("pre_erase_free", 32'(free_cnt), 3);
        chk("pre_erase_active", 32'(active_blk_num), 12);
        repeat (4) inval(4'd4);
        wait_req("req_before_pass5");
        grant();
        repeat (16) tick();
        chk("erase_cycle_busy", 32'({busy, move_flag, req_done}), 3'b100);
        new_active_request = 1'b1;
        tick();
        new_active_request = 1'b0;
        chk("pushpop_req_done", 32'(req_done), 1);
        chk("pushpop_free", 32'(free_cnt), 3);
        chk("pushpop_active", 32'(active_blk_num), 13);
        chk("pushpop_victim", 32'(erase_blk_num), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
